// File: rtl/life_row_engine.sv
// Cellular-automaton row engine: one next-state cell per pixel clock from three buffered rows,
// with programmable birth/survive masks, LFSR-driven random seeding and a generation counter.
module life_row_engine #(
    parameter int unsigned WIDTH     = 640,
    parameter int unsigned ROWS      = 480,
    parameter int unsigned COL_BITS  = 10,
    parameter int unsigned ROW_BITS  = 9,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clkDiv,
    input  logic                rst,
    input  logic                noise,
    input  logic                reading,
    input  logic [WIDTH-1:0]    readRow,
    input  logic                displayActive,
    input  logic [ROW_BITS-1:0] row,
    input  logic [COL_BITS-1:0] column,
    input  logic                wrap,
    input  logic                pause,
    input  logic [8:0]          birthMask,
    input  logic [8:0]          surviveMask,
    input  logic                seedRequest,
    input  logic [7:0]          density,
    output logic [WIDTH-1:0]    drawRow,
    output logic [WIDTH-1:0]    writeRow,
    output logic                seeding,
    output logic [15:0]         generation
);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(WIDTH - 1);
    localparam logic [ROW_BITS-1:0] ROW_END  = ROW_BITS'(ROWS);
    localparam logic [ROW_BITS-1:0] ROW_ARM  = ROW_BITS'(ROWS + 1);

    // Bit 1 of the state is the seeding flag, bit 0 a pending seed request.
    typedef enum logic [1:0] {
        S_IDLE       = 2'b00,
        S_ARMED      = 2'b01,
        S_SEED       = 2'b10,
        S_SEED_ARMED = 2'b11
    } seed_state_t;

    seed_state_t         r_state, w_state_next;
    logic [WIDTH-1:0]    r_row_above, r_row_cur, r_row_next;
    logic [15:0]         r_lfsr, r_generation;
    logic                r_read_prev;

    logic                w_at_arm, w_at_end, w_gen_tick, w_load;
    logic [COL_BITS-1:0] w_col_l, w_col_r;
    logic                w_l_ok, w_r_ok, w_col_ok;
    logic [3:0]          w_count;
    logic                w_next_bit;
    logic [15:0]         w_lfsr_shift, w_lfsr_next;

    assign w_at_arm   = (row == ROW_ARM);
    assign w_at_end   = (row == ROW_END);
    assign w_gen_tick = w_at_end && (column == '0);
    assign w_load     = reading && !r_read_prev;

    // Horizontal neighbour columns; edge columns either wrap around or read as dead.
    assign w_col_ok = (column <= LAST_COL);
    assign w_col_l  = (column == '0) ? LAST_COL : column - COL_BITS'(1);
    assign w_col_r  = (column == LAST_COL) ? '0 : column + COL_BITS'(1);
    assign w_l_ok   = wrap || (column != '0);
    assign w_r_ok   = wrap || (column != LAST_COL);

    always_comb begin
        w_count = 4'(r_row_above[column]) + 4'(readRow[column]);
        if (w_l_ok) begin
            w_count = w_count + 4'(r_row_above[w_col_l]) + 4'(r_row_cur[w_col_l])
                              + 4'(readRow[w_col_l]);
        end
        if (w_r_ok) begin
            w_count = w_count + 4'(r_row_above[w_col_r]) + 4'(r_row_cur[w_col_r])
                              + 4'(readRow[w_col_r]);
        end
    end

    always_comb begin
        w_next_bit = 1'b0;
        if (r_state[1]) begin
            w_next_bit = (r_lfsr[7:0] < density);
        end else if (pause) begin
            w_next_bit = r_row_cur[column];
        end else if (r_row_cur[column]) begin
            w_next_bit = surviveMask[w_count];
        end else begin
            w_next_bit = birthMask[w_count];
        end
    end

    // Fibonacci LFSR (taps 16,14,13,11) stirred by noise; never allowed to lock at zero.
    assign w_lfsr_shift = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10] ^ noise};
    assign w_lfsr_next  = (w_lfsr_shift == 16'h0) ? LFSR_SEED : w_lfsr_shift;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (seedRequest) w_state_next = S_ARMED;
            end
            S_ARMED: begin
                if (w_at_arm) w_state_next = seedRequest ? S_SEED_ARMED : S_SEED;
            end
            S_SEED: begin
                if (w_at_end)         w_state_next = seedRequest ? S_ARMED : S_IDLE;
                else if (seedRequest) w_state_next = S_SEED_ARMED;
            end
            S_SEED_ARMED: begin
                if (w_at_end) w_state_next = S_ARMED;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clkDiv or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clkDiv or posedge rst) begin
        if (rst) begin
            r_row_above  <= '0;
            r_row_cur    <= '0;
            r_row_next   <= '0;
            r_lfsr       <= LFSR_SEED;
            r_read_prev  <= 1'b0;
            r_generation <= 16'h0;
        end else begin
            r_read_prev <= reading;
            r_lfsr      <= w_lfsr_next;
            if (w_load) begin
                r_row_above <= r_row_cur;
                r_row_cur   <= readRow;
            end
            if (displayActive && w_col_ok) begin
                r_row_next[column] <= w_next_bit;
            end
            if (w_gen_tick) begin
                r_generation <= r_state[1] ? 16'h0 : r_generation + 16'd1;
            end
        end
    end

    assign drawRow    = r_row_cur;
    assign writeRow   = r_row_next;
    assign seeding    = r_state[1];
    assign generation = r_generation;

endmodule

// File: tb/tb_life_row_engine.sv
// Directed bench for life_row_engine: each row scan pushes a model-computed next row to a
// scoreboard that is popped and compared once the scan has been written.
module tb_life_row_engine;
    localparam int WIDTH = 640;
    localparam int ROWS  = 480;
    localparam logic [15:0] SEED = 16'hACE1;

    logic             clkDiv = 1'b0;
    logic             rst, noise, reading, displayActive, wrap, pause, seedRequest;
    logic [WIDTH-1:0] readRow;
    logic [8:0]       row;
    logic [9:0]       column;
    logic [8:0]       birthMask, surviveMask;
    logic [7:0]       density;
    logic [WIDTH-1:0] drawRow, writeRow;
    logic             seeding;
    logic [15:0]      generation;

    always #5 clkDiv = ~clkDiv;

    life_row_engine #(
        .WIDTH(WIDTH), .ROWS(ROWS), .COL_BITS(10), .ROW_BITS(9), .LFSR_SEED(SEED)
    ) dut (
        .clkDiv(clkDiv), .rst(rst), .noise(noise), .reading(reading), .readRow(readRow),
        .displayActive(displayActive), .row(row), .column(column), .wrap(wrap), .pause(pause),
        .birthMask(birthMask), .surviveMask(surviveMask), .seedRequest(seedRequest),
        .density(density), .drawRow(drawRow), .writeRow(writeRow), .seeding(seeding),
        .generation(generation)
    );

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    logic [WIDTH-1:0] m_above, m_cur;
    logic [15:0]      m_lfsr;
    logic             exp_seed;
    logic [WIDTH-1:0] exp_q[$];
    string            tag_q[$];

    function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic n);
        logic [15:0] t;
        t = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ n};
        return (t == 16'h0) ? SEED : t;
    endfunction

    always @(posedge clkDiv or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= lfsr_step(m_lfsr, noise);
    end

    // Reference cell rule: sum the 3x3 window minus the centre, honouring the edge mode.
    function automatic logic ref_cell(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] cu,
                                      input logic [WIDTH-1:0] b, input int c);
        int n;
        int k;
        n = 0;
        for (int dc = -1; dc <= 1; dc++) begin
            k = c + dc;
            if (k < 0 || k >= WIDTH) begin
                if (!wrap) continue;
                k = (k + WIDTH) % WIDTH;
            end
            n = n + int'(a[k]) + int'(b[k]);
            if (dc != 0) n = n + int'(cu[k]);
        end
        if (exp_seed) return (m_lfsr[7:0] < density);
        if (pause)    return cu[c];
        return cu[c] ? surviveMask[n] : birthMask[n];
    endfunction

    function automatic logic [WIDTH-1:0] rand_row();
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] bits(input int lo, input int hi);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_row(input logic [WIDTH-1:0] v);
        readRow = v;
        reading = 1'b1;
        @(negedge clkDiv);
        reading = 1'b0;
        @(negedge clkDiv);
        m_above = m_cur;
        m_cur   = v;
    endtask

    task automatic hold(input int r, input int c, input int n);
        row    = 9'(r);
        column = 10'(c);
        repeat (n) @(negedge clkDiv);
        column = 10'd700;
    endtask

    task automatic scan_row(input string tag, input int r, input logic mid_chg,
                            input logic [WIDTH-1:0] mid_row, input logic rnd_noise);
        logic [WIDTH-1:0] e;
        e = '0;
        row = 9'(r);
        displayActive = 1'b1;
        for (int c = 0; c < WIDTH; c++) begin
            if (mid_chg && c == WIDTH / 2) readRow = mid_row;
            if (rnd_noise) noise = 1'($urandom_range(0, 1));
            column = 10'(c);
            e[c] = ref_cell(m_above, m_cur, readRow, c);
            @(negedge clkDiv);
        end
        displayActive = 1'b0;
        noise  = 1'b0;
        column = 10'd700;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        logic [WIDTH-1:0] e;
        string t;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", WIDTH'(1), WIDTH'(0));
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, writeRow, e);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] b10, pat, r1, r2;
        int pc;

        rst = 1'b0; noise = 1'b0; reading = 1'b0; displayActive = 1'b0;
        wrap = 1'b0; pause = 1'b0; seedRequest = 1'b0; density = 8'h00;
        readRow = '0; row = 9'd0; column = 10'd700;
        birthMask = 9'h008; surviveMask = 9'h00C;
        m_above = '0; m_cur = '0; exp_seed = 1'b0;
        #1 rst = 1'b1;
        @(negedge clkDiv); @(negedge clkDiv);
        check("rst_drawRow", drawRow, '0);
        check("rst_writeRow", writeRow, '0);
        check("rst_seeding", WIDTH'(seeding), WIDTH'(0));
        check("rst_generation", WIDTH'(generation), WIDTH'(0));
        rst = 1'b0;
        @(negedge clkDiv);

        // Conway vertical blinker at column 10, dead edges.
        b10 = bits(10, 10);
        load_row('0);
        load_row(b10);
        check("load_drawRow", drawRow, b10);
        readRow = b10;
        scan_row("blinker_above_model", 19, 1'b0, '0, 1'b0);
        pop_check();
        check("blinker_above_const", writeRow, '0);
        load_row(b10);
        readRow = b10;
        scan_row("blinker_mid_model", 20, 1'b0, '0, 1'b0);
        pop_check();
        check("blinker_mid_const", writeRow, bits(9, 11));
        load_row(b10);
        readRow = '0;
        scan_row("blinker_below_model", 21, 1'b0, '0, 1'b0);
        pop_check();
        check("blinker_below_const", writeRow, '0);

        // Toroidal versus dead horizontal edge at column 0.
        load_row('0);
        load_row(bits(0, 0) | bits(WIDTH - 1, WIDTH - 1));
        readRow = bits(WIDTH - 1, WIDTH - 1);
        wrap = 1'b1;
        scan_row("wrap1_model", 30, 1'b0, '0, 1'b0);
        pop_check();
        check("wrap1_bit0", WIDTH'(writeRow[0]), WIDTH'(1));
        wrap = 1'b0;
        scan_row("wrap0_model", 30, 1'b0, '0, 1'b0);
        pop_check();
        check("wrap0_bit0", WIDTH'(writeRow[0]), WIDTH'(0));

        // B36/S23: dead cell at 100 with six neighbours.
        load_row(bits(99, 101));
        load_row('0);
        readRow = bits(99, 101);
        birthMask = 9'h048;
        scan_row("b36_model", 40, 1'b0, '0, 1'b0);
        pop_check();
        check("b36_bit100", WIDTH'(writeRow[100]), WIDTH'(1));
        birthMask = 9'h008;
        scan_row("b3_model", 40, 1'b0, '0, 1'b0);
        pop_check();
        check("b3_bit100", WIDTH'(writeRow[100]), WIDTH'(0));

        // Random rows with readRow changing mid-scan.
        r1 = rand_row(); r2 = rand_row();
        load_row(rand_row());
        load_row(r1);
        readRow = r2;
        wrap = 1'b1;
        scan_row("rand_wrap_conway", 50, 1'b1, rand_row(), 1'b0);
        pop_check();
        wrap = 1'b0;
        birthMask = 9'(($urandom));
        surviveMask = 9'(($urandom));
        readRow = rand_row();
        scan_row("rand_nowrap_masks", 51, 1'b1, rand_row(), 1'b0);
        pop_check();
        birthMask = 9'h008; surviveMask = 9'h00C;

        // Pause copies the current row through.
        pat = {80{8'hA5}};
        load_row(pat);
        readRow = rand_row();
        pause = 1'b1;
        scan_row("pause_model", 60, 1'b0, '0, 1'b0);
        pop_check();
        check("pause_copy", writeRow, pat);
        pause = 1'b0;

        // Generation counts each row-480/column-0 cycle while not seeding.
        hold(ROWS, 0, 3);
        check("gen_count3", WIDTH'(generation), WIDTH'(16'd3));

        // Seed frame with density 0; a request during the frame is kept for the next one.
        row = 9'd100;
        seedRequest = 1'b1;
        @(negedge clkDiv);
        seedRequest = 1'b0;
        check("seed_armed_low", WIDTH'(seeding), WIDTH'(0));
        hold(ROWS + 1, 700, 1);
        check("seed_rise", WIDTH'(seeding), WIDTH'(1));
        exp_seed = 1'b1;
        density = 8'h00;
        scan_row("seed_d0_model", 0, 1'b0, '0, 1'b0);
        pop_check();
        check("seed_d0_const", writeRow, '0);
        row = 9'd200;
        seedRequest = 1'b1;
        @(negedge clkDiv);
        seedRequest = 1'b0;
        hold(ROWS, 0, 1);
        check("seed_fall", WIDTH'(seeding), WIDTH'(0));
        check("seed_gen_clear", WIDTH'(generation), WIDTH'(0));
        hold(ROWS + 1, 700, 1);
        check("seed_rearm_rise", WIDTH'(seeding), WIDTH'(1));

        // Second seed frame with density 0x80 and random noise.
        density = 8'h80;
        scan_row("seed_d80_noise", 3, 1'b0, '0, 1'b1);
        pop_check();
        hold(ROWS, 0, 1);
        check("seed2_fall", WIDTH'(seeding), WIDTH'(0));
        exp_seed = 1'b0;
        hold(ROWS + 1, 700, 1);
        check("idle_no_rise", WIDTH'(seeding), WIDTH'(0));
        hold(ROWS, 0, 1);
        check("gen_after_seed", WIDTH'(generation), WIDTH'(1));

        // Dense seed frame, then reset in the middle of it.
        row = 9'd10;
        seedRequest = 1'b1;
        @(negedge clkDiv);
        seedRequest = 1'b0;
        hold(ROWS + 1, 700, 1);
        exp_seed = 1'b1;
        density = 8'hFF;
        scan_row("seed_dff_model", 7, 1'b0, '0, 1'b0);
        pop_check();
        pc = 0;
        for (int i = 0; i < WIDTH; i++) pc += int'(writeRow[i]);
        check("seed_dff_dense", WIDTH'(pc >= 600), WIDTH'(1));
        check("seed_dff_seeding", WIDTH'(seeding), WIDTH'(1));
        #2 rst = 1'b1;
        #1;
        check("rst_async_seeding", WIDTH'(seeding), WIDTH'(0));
        check("rst_async_gen", WIDTH'(generation), WIDTH'(0));
        check("rst_async_writeRow", writeRow, '0);
        check("rst_async_drawRow", drawRow, '0);
        @(negedge clkDiv);
        rst = 1'b0;
        exp_seed = 1'b0;
        m_above = '0; m_cur = '0;
        hold(ROWS + 1, 700, 2);
        check("rst_no_pending", WIDTH'(seeding), WIDTH'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/life_row_engine.md
Name: life_row_engine

Overview:
Parametrised cellular-automaton row engine for the VGA life display. It holds the rows above, current and below around the row being scanned, and computes each cell's next state in step with the pixel scan. It writes results into a next-row buffer for the row-memory controller to store. It adds a programmable birth/survive rule, toroidal or dead horizontal edges, pause, density-controlled random seeding and a generation counter.

Parameters:
WIDTH, 640, cells per row (visible columns)
ROWS, 480, visible rows per frame
COL_BITS, 10, width of column input
ROW_BITS, 9, width of row input
LFSR_SEED, 16'hACE1, LFSR reset value and zero-lock recovery value

Ports:
clkDiv  input  1  pixel clock; all state on rising edge
rst  input  1  asynchronous active-high reset
noise  input  1  entropy bit XORed into LFSR feedback
reading  input  1  row-memory read phase; rising edge loads a new row
readRow  input  WIDTH  row below current row (live from memory)
displayActive  input  1  scan is within visible area
row  input  ROW_BITS  current scan row
column  input  COL_BITS  current scan column
wrap  input  1  1 = toroidal horizontal neighbours, 0 = out-of-range neighbours dead
pause  input  1  1 = next state equals current state
birthMask  input  9  bit n set: dead cell with n live neighbours becomes alive
surviveMask  input  9  bit n set: live cell with n live neighbours stays alive
seedRequest  input  1  one-cycle pulse; arms random fill of next frame
density  input  8  seeding: cell alive iff lfsr[7:0] < density
drawRow  output  WIDTH  current row (rowCur), for pixel output
writeRow  output  WIDTH  computed next row (rowNext)
seeding  output  1  high while a seed frame is being written
generation  output  16  frames computed since last seed

Behaviour:
- Reset: rowAbove, rowCur, rowNext = 0; lfsr = LFSR_SEED; readPrev, seedPending, seeding = 0; generation = 0.
- readPrev <= reading every cycle. On reading=1 and readPrev=0: rowAbove <= rowCur and rowCur <= readRow in the same edge. rowNext is unchanged.
- Neighbour count n(c) is 0..8 over rowAbove, rowCur and readRow at columns c-1, c and c+1, excluding rowCur[c].
- wrap=1: column -1 maps to WIDTH-1 and column WIDTH maps to 0. wrap=0: these columns count as 0. Vertical edges are the controller's responsibility.
- Update: on the edge ending a cycle with displayActive=1 and column=c<WIDTH, rowNext[c] is written with this priority:
  - seeding=1: (lfsr[7:0] < density)
  - else pause=1: rowCur[c]
  - else rowCur[c] ? surviveMask[n(c)] : birthMask[n(c)]
- Latency is exactly one cycle from scan column to rowNext bit. Internal pipelining is allowed, but the result must be identical. Counts must use values as they stand at column c, including a readRow that changes mid-row.
- No rowNext write when displayActive=0 or column>=WIDTH.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Feedback is XORed with noise. It advances every cycle. If the next value would be 0, load LFSR_SEED instead.
- Seeding FSM:
  - IDLE: seedRequest sets seedPending.
  - seedPending=1 and row==ROWS+1: seeding <= 1, seedPending <= 0 (ARMED to SEED).
  - seeding=1 and row==ROWS: seeding <= 0 (SEED to IDLE).
  - seedRequest during SEED sets seedPending; that fill starts at the next ROWS+1.
  - seedRequest coincident with clearing is kept, not lost.
- Generation counter:
  - Evaluated on the cycle with row==ROWS and column==0.
  - If seeding=1 on that cycle, generation <= 0.
  - Else generation <= generation+1, wrapping 16'hFFFF to 0.
  - A paused frame still increments.
- Reset mid-frame aborts seeding and pending requests immediately; outputs return to reset values asynchronously.
- Mask or wrap changes take effect on the next cell computed.

Test Plan:
- Conway (birthMask=9'h008, surviveMask=9'h00C), wrap=0: vertical blinker at column 10 across rows r-1, r, r+1 -> rowNext for row r has bits 9, 10, 11 set only; row r±1 results have no bits set.
- wrap=1: rowCur bits 0 and WIDTH-1 set, readRow bit WIDTH-1 set -> count at c=0 is 2, so bit 0 survives. The same input with wrap=0 kills bit 0.
- B36/S23 (birthMask=9'h048, surviveMask=9'h00C): dead cell at c=100 with exactly 6 neighbours -> rowNext[100]=1. With birthMask=9'h008, rowNext[100]=0.
- pause=1 with arbitrary rowCur=640'hA5A5... -> writeRow equals rowCur after a full row scan.
- seedRequest pulse mid-frame with density=0 -> seeding rises at row 481 and falls at row 480. Every rowNext bit is 0 for that frame, generation reads 0 after row 480 column 0, then increments by 1 per frame.
- density=8'hFF, noise held 0 -> ~255/256 of cells alive. LFSR is never 0 over 2^17 cycles. Asserting rst during SEED clears seeding and generation the same cycle.
